// File: rtl/microwave_timer.sv
// Microwave cook-time countdown in M:SS BCD: digits shift in from the right, then count down per tick.
// Optional one-cycle completion pulse on `done` when built with TIMER_DONE_PULSE_EN.
module microwave_timer #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic       clock,
    input  logic       clearn,
    input  logic [3:0] data,
    input  logic       loadn,
    input  logic       enable,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min,
    output logic       zero
`ifdef TIMER_DONE_PULSE_EN
    ,
    output logic       done
`endif
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [3:0]    ones_q, ones_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    min_q, min_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          load;
    logic          tick;
    logic          is_zero;
    logic          at_one;

    assign is_zero = (min_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd0);
    assign at_one  = (min_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd1);
    assign load    = !loadn && !enable && (data <= 4'd9);
    assign tick    = enable && (pre_q == PRE_LAST);

    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        min_d  = min_q;
        pre_d  = pre_q;
        if (load) begin
            min_d  = tens_q;
            tens_d = (ones_q > 4'd5) ? 4'd5 : ones_q;
            ones_d = data;
            pre_d  = '0;
        end else if (enable) begin
            pre_d = tick ? '0 : pre_q + PW'(1);
            // Seconds borrow ripples into tens (modulo 6) and then minutes.
            if (tick && !is_zero) begin
                if (ones_q == 4'd0) begin
                    ones_d = 4'd9;
                    if (tens_q == 4'd0) begin
                        tens_d = 4'd5;
                        min_d  = min_q - 4'd1;
                    end else begin
                        tens_d = tens_q - 4'd1;
                    end
                end else begin
                    ones_d = ones_q - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            ones_q <= '0;
            tens_q <= '0;
            min_q  <= '0;
            pre_q  <= '0;
        end else begin
            ones_q <= ones_d;
            tens_q <= tens_d;
            min_q  <= min_d;
            pre_q  <= pre_d;
        end
    end

`ifdef TIMER_DONE_PULSE_EN
    logic done_q, done_d;

    // Set by the same edge that takes 0:01 to 0:00, so it is high only while 0:00 is first shown.
    assign done_d = tick && at_one;

    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

    assign done = done_q;
`else
    logic unused_at_one;
    assign unused_at_one = at_one;
`endif

    assign sec_ones = ones_q;
    assign sec_tens = tens_q;
    assign min      = min_q;
    assign zero     = is_zero;

endmodule

// File: tb/tb_microwave_timer.sv
// Directed and randomized bench for microwave_timer; reference model works in total seconds.
module tb_microwave_timer;

    localparam int unsigned TICK_DIV = 1;

    logic       clock;
    logic       clearn;
    logic [3:0] data;
    logic       loadn;
    logic       enable;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min;
    logic       zero;
`ifdef TIMER_DONE_PULSE_EN
    logic       done;
`endif

    microwave_timer #(.TICK_DIV(TICK_DIV)) dut (
        .clock   (clock),
        .clearn  (clearn),
        .data    (data),
        .loadn   (loadn),
        .enable  (enable),
        .sec_ones(sec_ones),
        .sec_tens(sec_tens),
        .min     (min),
        .zero    (zero)
`ifdef TIMER_DONE_PULSE_EN
        ,
        .done    (done)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    int m_min  = 0;
    int m_tens = 0;
    int m_ones = 0;
    int m_pre  = 0;
    int m_done = 0;
    int done_count = 0;

    task automatic model_reset();
        m_min = 0; m_tens = 0; m_ones = 0; m_pre = 0; m_done = 0;
    endtask

    task automatic model_edge(input logic ln, input logic en, input logic [3:0] d);
        int secs;
        m_done = 0;
        if (!en) begin
            if (!ln && d <= 4'd9) begin
                m_min  = m_tens;
                m_tens = (m_ones > 5) ? 5 : m_ones;
                m_ones = int'(d);
                m_pre  = 0;
            end
        end else begin
            m_pre++;
            if (m_pre == TICK_DIV) begin
                m_pre = 0;
                secs = m_min * 60 + m_tens * 10 + m_ones;
                if (secs > 0) begin
                    secs--;
                    if (secs == 0) m_done = 1;
                end
                m_min  = secs / 60;
                m_tens = (secs % 60) / 10;
                m_ones = secs % 10;
            end
        end
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".min"},  int'(min),      m_min);
        chk({tag, ".tens"}, int'(sec_tens), m_tens);
        chk({tag, ".ones"}, int'(sec_ones), m_ones);
        chk({tag, ".zero"}, int'(zero), (m_min == 0 && m_tens == 0 && m_ones == 0) ? 1 : 0);
`ifdef TIMER_DONE_PULSE_EN
        chk({tag, ".done"}, int'(done), m_done);
        if (done === 1'b1) done_count++;
`endif
    endtask

    task automatic chk_time(input string tag, input int mm, input int tt, input int oo, input int zz);
        chk({tag, ".min"},  int'(min),      mm);
        chk({tag, ".tens"}, int'(sec_tens), tt);
        chk({tag, ".ones"}, int'(sec_ones), oo);
        chk({tag, ".zero"}, int'(zero),     zz);
    endtask

    // Drive inputs, take one rising edge, advance the model, then compare.
    task automatic step(input string tag, input logic ln, input logic en, input logic [3:0] d);
        loadn = ln; enable = en; data = d;
        @(posedge clock);
        model_edge(ln, en, d);
        #1;
        chk_model(tag);
    endtask

    task automatic key(input string tag, input logic [3:0] d);
        step(tag, 1'b0, 1'b0, d);
    endtask

    initial begin
        clearn = 1'b0; loadn = 1'b1; enable = 1'b0; data = 4'd0;
        model_reset();
        #2;
        chk_time("reset", 0, 0, 0, 1);
        @(posedge clock); #1;
        chk_time("reset_held", 0, 0, 0, 1);
        clearn = 1'b1;

        key("k1", 4'd1); key("k3", 4'd3); key("k0", 4'd0);
        chk_time("entry130", 1, 3, 0, 0);

        step("cd1", 1'b1, 1'b1, 4'd0);
        chk_time("t129", 1, 2, 9, 0);
        for (int i = 2; i <= 90; i++) begin
            step("cd", 1'b1, 1'b1, 4'd0);
            if (i == 31) chk_time("t059", 0, 5, 9, 0);
        end
        chk_time("t000", 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) step("hold0", 1'b1, 1'b1, 4'd0);
        chk_time("still000", 0, 0, 0, 1);

        step("idle", 1'b1, 1'b0, 4'd0);
        key("r1", 4'd1); key("r3", 4'd3); key("r0", 4'd0);
        for (int i = 0; i < 5; i++) step("rc", 1'b1, 1'b1, 4'd0);
        chk_time("pre_reset", 1, 2, 5, 0);
        clearn = 1'b0;
        #1;
        model_reset();
        chk_time("async_clr", 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            loadn = 1'b0; enable = (i == 1); data = 4'd4;
            @(posedge clock); #1;
            chk_time("clr_held", 0, 0, 0, 1);
        end
        loadn = 1'b1; enable = 1'b0;
        clearn = 1'b1;

        key("k7", 4'd7); key("k8", 4'd8);
        chk_time("sat58", 0, 5, 8, 0);
        key("k12", 4'd12);
        chk_time("ign12", 0, 5, 8, 0);
        step("ld_en", 1'b0, 1'b1, 4'd3);
        chk_time("ign_en", 0, 5, 7, 0);

        key("p0", 4'd0); key("p0b", 4'd0); key("p5", 4'd5);
        chk_time("p005", 0, 0, 5, 0);
        step("pc1", 1'b1, 1'b1, 4'd0); step("pc2", 1'b1, 1'b1, 4'd0);
        for (int i = 0; i < 5; i++) step("pause", 1'b1, 1'b0, 4'd0);
        chk_time("p003", 0, 0, 3, 0);
        for (int i = 0; i < 3; i++) step("resume", 1'b1, 1'b1, 4'd0);
        chk_time("p000", 0, 0, 0, 1);

`ifdef TIMER_DONE_PULSE_EN
        step("d_idle", 1'b1, 1'b0, 4'd0);
        key("d0", 4'd0); key("d0b", 4'd0); key("d2", 4'd2);
        done_count = 0;
        for (int i = 0; i < 6; i++) step("dcnt", 1'b1, 1'b1, 4'd0);
        chk("done_once", done_count, 1);
        step("d_idle2", 1'b1, 1'b0, 4'd0);
        key("z0", 4'd0); key("z0b", 4'd0); key("z0c", 4'd0);
        done_count = 0;
        for (int i = 0; i < 5; i++) step("zcnt", 1'b1, 1'b1, 4'd0);
        chk("done_none", done_count, 0);
`endif

        for (int i = 0; i < 400; i++) begin
            logic       ln, en;
            logic [3:0] d;
            ln = ($urandom_range(0, 3) != 0);
            en = ($urandom_range(0, 2) == 0);
            d  = 4'($urandom_range(0, 15));
            step("rand", ln, en, d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
